ysyx_24100012_lsu: RTL and testbench

Load/store unit for the NPC core. It sits directly downstream of the ALU: it takes the ALU result as the effective address and the rs2 register value as store data. It runs one multi-cycle transaction on a simple valid/ready data-memory bus and returns the sign- or zero-extended load value that feeds the write-back mux's DMemLoad input. It replaces the single-cycle data RAM path so the core can stall on real memory latency.

---
 rtl/ysyx_24100012_lsu.sv | 150 +++++++++++++++
 tb/tb_ysyx_24100012_lsu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_lsu.sv
// Load/store unit: one multi-cycle valid/ready data-memory transaction per request.
// Latency: store 2 cycles, load 3 cycles (+ bus stalls), illegal/trapped request 1 cycle.
// Backpressure: req_ready only in IDLE; stalls on mem_ready and mem_rvalid. Macro LSU_MISALIGN_TRAP_EN.
module ysyx_24100012_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state;
  logic                  wen_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  illegal;
  logic                  misalign;
  logic [1:0]            off;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_val;

  // Classify the incoming request: illegal funct3 and (optionally) misalignment go straight to DONE.
  always_comb begin
    illegal  = req_wen ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                       : ((req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11));
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b0;
    endcase
`endif
  end

  // Effective byte offset; halfwords and words are forced aligned (only reachable untrapped).
  always_comb begin
    case (f3_q[1:0])
      2'b00:   off = addr_q[1:0];
      2'b01:   off = {addr_q[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  // Bus request fields come straight from the latched request, so they hold through stalls.
  always_comb begin
    mem_valid = (state == REQ);
    mem_wen   = mem_valid & wen_q;
    mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    case (f3_q[1:0])
      2'b00:   mem_wdata = {4{wdata_q[7:0]}};
      2'b01:   mem_wdata = {2{wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
    mem_wstrb = 4'b0000;
    if (wen_q) begin
      case (f3_q[1:0])
        2'b00:   mem_wstrb = 4'b0001 << off;
        2'b01:   mem_wstrb = 4'b0011 << off;
        default: mem_wstrb = 4'b1111;
      endcase
    end
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    shifted = mem_rdata >> {off, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Transaction sequencing: IDLE -> REQ -> (WAIT for loads) -> DONE -> IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (req_valid) state <= (illegal | misalign) ? DONE : REQ;
        REQ:     if (mem_ready) state <= wen_q ? DONE : WAIT;
        WAIT:    if (mem_rvalid) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Latch the request at acceptance so the core may change its inputs afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req_valid) begin
      wen_q   <= req_wen;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response registers: load data on capture, zero for stores and errors; held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          resp_err <= illegal | misalign;
          if (illegal | misalign) resp_rdata <= '0;
        end
        REQ:  if (mem_ready && wen_q) resp_rdata <= '0;
        WAIT: if (mem_rvalid) resp_rdata <= load_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
// Randomized self-checking bench for ysyx_24100012_lsu against a byte-level reference model.
// Drives and samples on the falling clock edge; every wait is a fixed cycle count.
// Covers reset, mid-transaction reset, directed lane cases and random traffic with stalls.
module tb_ysyx_24100012_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_24100012_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: access size in bytes, legality, alignment, lane placement and extension.
  function automatic void ref_model(input logic wen, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] rdata, output logic err,
                                    output logic [3:0] strb, output logic [31:0] bus_wdata,
                                    output logic [31:0] load_val);
    int sz, o;
    logic legal, mis;
    logic [63:0] v;
    sz = 1 << f3[1:0];
    if (wen) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else     legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    o = int'(addr[1:0]);
    mis = legal && ((o % sz) != 0);
`ifdef LSU_MISALIGN_TRAP_EN
    err = !legal || mis;
`else
    err = !legal;
    o = o - (o % sz);
`endif
    strb = 4'b0;
    bus_wdata = 32'b0;
    load_val = 32'b0;
    if (!err) begin
      for (int i = 0; i < 4; i++) begin
        bus_wdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
        if (wen && i >= o && i < o + sz) strb[i] = 1'b1;
      end
      if (!wen) begin
        v = 64'b0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rdata[8*(o+i) +: 8];
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (64'd1 << (8*sz));
        load_val = v[31:0];
      end
    end
  endfunction

  // One full transaction starting at a falling edge with the DUT idle.
  task automatic run_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int rdly, input int vdly);
    logic err;
    logic [3:0] strb;
    logic [31:0] bw, lv;
    ref_model(wen, f3, addr, wdata, rdata, err, strb, bw, lv);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_wen = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (!err) begin
      for (int k = 0; k <= rdly; k++) begin
        check("req_mem_valid", 32'(mem_valid), 32'd1);
        check("req_mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("req_mem_wen", 32'(mem_wen), 32'(wen));
        check("req_mem_wstrb", 32'(mem_wstrb), 32'(strb));
        if (wen) check("req_mem_wdata", mem_wdata, bw);
        check("req_ready_busy", 32'(req_ready), 32'd0);
        mem_ready = (k == rdly);
        mem_rvalid = 1'($urandom);
        mem_rdata = $urandom;
        @(posedge clk); @(negedge clk);
      end
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (!wen) begin
        for (int k = 0; k <= vdly; k++) begin
          check("wait_mem_valid", 32'(mem_valid), 32'd0);
          check("wait_resp_valid", 32'(resp_valid), 32'd0);
          mem_rvalid = (k == vdly);
          mem_rdata = (k == vdly) ? rdata : $urandom;
          @(posedge clk); @(negedge clk);
        end
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end
    check("done_resp_valid", 32'(resp_valid), 32'd1);
    check("done_resp_err", 32'(resp_err), 32'(err));
    check("done_resp_rdata", resp_rdata, lv);
    check("done_mem_valid", 32'(mem_valid), 32'd0);
    check("done_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    check("after_resp_valid", 32'(resp_valid), 32'd0);
    check("after_resp_rdata_hold", resp_rdata, lv);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b0; req_addr = 32'b0; req_wdata = 32'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    run_txn(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 0);
    run_txn(1'b0, 3'b000, 32'h8000_0001, 32'h0, 32'h1234_F678, 0, 0);
    run_txn(1'b0, 3'b100, 32'h8000_0001, 32'h0, 32'h1234_F678, 0, 0);
    run_txn(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h1234_F678, 0, 0);
    run_txn(1'b1, 3'b001, 32'h8000_0002, 32'hCAFE_BEEF, 32'h0, 3, 0);
    run_txn(1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 3, 5);
    run_txn(1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h8765_4321, 0, 0);
    run_txn(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
    run_txn(1'b1, 3'b100, 32'h8000_0000, 32'h1111_1111, 32'h0, 0, 0);
    run_txn(1'b0, 3'b001, 32'h8000_0003, 32'h0, 32'hA5B6_C7D8, 1, 1);

    // Reset in the middle of a bus request
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8000_0010;
    req_wdata = 32'h5555_AAAA;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b0;
    check("midrst_mem_valid_before", 32'(mem_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_mem_valid", 32'(mem_valid), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_no_resp", 32'(resp_valid), 32'd0);
      check("midrst_no_bus", 32'(mem_valid), 32'd0);
    end
    mem_ready = 1'b0;

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = $urandom;
      run_txn(1'($urandom), 3'($urandom), a, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
